// File: rtl/ysyx_24070016_mem_pkg.sv
// rtl/ysyx_24070016_mem_pkg.sv - shared op encodings, size decode and FSM states for the dmem responder
package ysyx_24070016_mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_B, OP_H, OP_W, OP_BU, OP_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Signedness lives in op[2] and is the initiator's concern; only the size matters here.
  function automatic logic [1:0] op_size(input logic [2:0] op);
    return op[1:0];
  endfunction

endpackage

// File: rtl/ysyx_24070016_mem_lane.sv
// rtl/ysyx_24070016_mem_lane.sv - byte-lane align/mask for sub-word loads and stores
module ysyx_24070016_mem_lane
  import ysyx_24070016_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_mask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_al,
  output logic        misaligned
);

  logic [3:0]  size_mask;
  logic [31:0] data_mask;
  logic [4:0]  shamt;

  always_comb begin
    size_mask  = 4'b0000;
    data_mask  = 32'h0;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        size_mask = 4'b0001;
        data_mask = 32'h0000_00ff;
      end
      SZ_H: begin
        size_mask  = 4'b0011;
        data_mask  = 32'h0000_ffff;
        misaligned = addr_lo[0];
      end
      SZ_W: begin
        size_mask  = 4'b1111;
        data_mask  = 32'hffff_ffff;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
    shamt     = {addr_lo, 3'b000};
    byte_mask = size_mask << addr_lo;
    wdata_sh  = wdata << shamt;
    rdata_al  = (rword >> shamt) & data_mask;
  end

endmodule

// File: rtl/ysyx_24070016_dmem_responder.sv
// rtl/ysyx_24070016_dmem_responder.sv - fixed-latency load/store responder over a word array
module ysyx_24070016_dmem_responder
  import ysyx_24070016_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               l_wren;
  logic [2:0]         l_op;
  logic [31:0]        l_addr;
  logic [31:0]        l_wdata;

  logic [31:0]        mem [DEPTH_WORDS];

  logic [31:0]        offset;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        rword;
  logic [3:0]         byte_mask;
  logic [31:0]        wdata_sh;
  logic [31:0]        rdata_al;
  logic               misaligned;
  logic               acc_err;
  logic               do_access;

  always_comb begin
    offset    = l_addr - ADDR_BASE;
    in_range  = (l_addr >= ADDR_BASE) && ({2'b00, offset[31:2]} < DEPTH_WORDS);
    idx       = offset[IDX_W+1:2];
    rword     = mem[idx];
    acc_err   = !op_legal(l_op) || misaligned || !in_range;
    do_access = (state == ST_BUSY) && (cnt == '0);
  end

  ysyx_24070016_mem_lane u_lane (
    .addr_lo    (l_addr[1:0]),
    .size       (op_size(l_op)),
    .wdata      (l_wdata),
    .rword      (rword),
    .byte_mask  (byte_mask),
    .wdata_sh   (wdata_sh),
    .rdata_al   (rdata_al),
    .misaligned (misaligned)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      l_wren    <= 1'b0;
      l_op      <= 3'b000;
      l_addr    <= 32'h0;
      l_wdata   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            l_wren    <= req_wren;
            l_op      <= req_op;
            l_addr    <= req_addr;
            l_wdata   <= req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= ST_BUSY;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || l_wren) ? 32'h0 : rdata_al;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The array has no reset; a reset mid-BUSY leaves state IDLE so the pending store never fires.
  always_ff @(posedge clock) begin
    if (do_access && l_wren && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_mask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24070016_dmem_responder.sv
// tb/tb_ysyx_24070016_dmem_responder.sv - self-checking bench for the dmem responder
module tb_ysyx_24070016_dmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT_A = 2;
  localparam int          LAT_B = 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        a_req_valid = 0, a_req_wren = 0, a_rsp_ready = 1;
  logic [2:0]  a_req_op = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid = 0, b_req_wren = 0, b_rsp_ready = 1;
  logic [2:0]  b_req_op = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  bit [7:0] mb [bit [31:0]];

  ysyx_24070016_dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT_A), .INIT_FILE("")) u_dut_a (
    .clock(clock), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wren(a_req_wren), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  ysyx_24070016_dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT_B), .INIT_FILE("")) u_dut_b (
    .clock(clock), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wren(b_req_wren), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  // Byte-addressed reference memory for the LATENCY=2 instance.
  task automatic ref_access(input bit wren, input bit [2:0] op, input bit [31:0] addr,
                            input bit [31:0] wdata, output bit [31:0] rd, output bit err);
    int nbytes;
    bit legal;
    longint off;
    legal  = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
    nbytes = 1 << op[1:0];
    off    = longint'(addr) - longint'(BASE);
    err    = !legal || ((addr % nbytes) != 0) || (off < 0) || ((off / 4) >= DEPTH);
    rd     = 32'h0;
    if (!err) begin
      for (int i = 0; i < nbytes; i++) begin
        if (wren) mb[addr + i] = wdata[8*i +: 8];
        else rd[8*i +: 8] = mb.exists(addr + i) ? mb[addr + i] : 8'h00;
      end
    end
  endtask

  // Drives one request on instance A with rsp_ready high; called and left at posedge+1.
  task automatic a_xact(input bit wren, input bit [2:0] op, input bit [31:0] addr, input bit [31:0] wdata,
                        output bit [31:0] rd, output bit err, output int lat, output bit ready_after,
                        output bit busy_ok);
    int n;
    a_req_wren = wren; a_req_op = op; a_req_addr = addr; a_req_wdata = wdata; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    a_req_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!a_rsp_valid && lat < 40) begin
      if (a_req_ready) busy_ok = 1'b0;
      @(posedge clock); #1; lat++;
    end
    rd = a_rsp_rdata;
    err = a_rsp_err;
    @(posedge clock); #1;
    ready_after = a_req_ready && !a_rsp_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({a_req_ready, a_rsp_valid, a_rsp_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {a_req_ready, a_rsp_valid, a_rsp_err});
    end
    checks++;
    if (a_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h required 00000000", a_rsp_rdata);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b%b required 11", a_req_ready, b_req_ready);
    end
  endtask

  task automatic test_word();
    bit [31:0] rd, erd; bit err, eerr, ra, bo; int lat;
    ref_access(1, 3'b010, BASE, 32'hDEAD_BEEF, erd, eerr);
    a_xact(1, 3'b010, BASE, 32'hDEAD_BEEF, rd, err, lat, ra, bo);
    checks++;
    if (lat !== LAT_A) begin errors++; $display("FAIL store_latency: got %0d required %0d", lat, LAT_A); end
    checks++;
    if ({err, rd} !== 33'h0) begin errors++; $display("FAIL store_rsp: got err=%b rdata=%h required 0/0", err, rd); end
    checks++;
    if ({ra, bo} !== 2'b11) begin errors++; $display("FAIL store_ready: got after=%b busy_ok=%b required 1/1", ra, bo); end
    a_xact(0, 3'b010, BASE, 32'h0, rd, err, lat, ra, bo);
    checks++;
    if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
      errors++; $display("FAIL load_word: got %h err=%b required deadbeef err=0", rd, err);
    end
    checks++;
    if (lat !== LAT_A) begin errors++; $display("FAIL load_latency: got %0d required %0d", lat, LAT_A); end
  endtask

  task automatic test_lanes();
    bit [31:0] rd, erd; bit err, eerr, ra, bo; int lat;
    ref_access(1, 3'b010, BASE, 32'h1122_3344, erd, eerr);
    a_xact(1, 3'b010, BASE, 32'h1122_3344, rd, err, lat, ra, bo);
    ref_access(1, 3'b000, BASE + 3, 32'h0000_005A, erd, eerr);
    a_xact(1, 3'b000, BASE + 3, 32'hFFFF_FF5A, rd, err, lat, ra, bo);
    a_xact(0, 3'b010, BASE, 32'h0, rd, err, lat, ra, bo);
    checks++;
    if (rd !== 32'h5A22_3344) begin errors++; $display("FAIL lane_word: got %h required 5a223344", rd); end
    a_xact(0, 3'b101, BASE + 2, 32'h0, rd, err, lat, ra, bo);
    checks++;
    if (rd !== 32'h0000_5A22) begin errors++; $display("FAIL lane_half_u: got %h required 00005a22", rd); end
    a_xact(0, 3'b000, BASE + 3, 32'h0, rd, err, lat, ra, bo);
    checks++;
    if (rd !== 32'h0000_005A) begin errors++; $display("FAIL lane_byte: got %h required 0000005a", rd); end
  endtask

  task automatic test_errors();
    bit        w  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit [2:0]  o  [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b000};
    bit [31:0] ad [5] = '{BASE + 2, BASE + 1, BASE - 4, BASE, BASE + DEPTH * 4};
    bit [31:0] rd; bit err, ra, bo; int lat;
    for (int i = 0; i < 5; i++) begin
      a_xact(w[i], o[i], ad[i], 32'hFFFF_FFFF, rd, err, lat, ra, bo);
      checks++;
      if (err !== 1'b1 || rd !== 32'h0) begin
        errors++; $display("FAIL err_case%0d: got err=%b rdata=%h required 1/00000000", i, err, rd);
      end
      a_xact(0, 3'b010, BASE, 32'h0, rd, err, lat, ra, bo);
      checks++;
      if (rd !== 32'h5A22_3344) begin errors++; $display("FAIL err_unchanged%0d: got %h required 5a223344", i, rd); end
    end
  endtask

  task automatic test_backpressure();
    bit [31:0] hold; int n;
    a_rsp_ready = 1'b0;
    a_req_wren = 0; a_req_op = 3'b001; a_req_addr = BASE; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 40) begin @(posedge clock); #1; n++; end
    hold = a_rsp_rdata;
    checks++;
    if (hold !== 32'h0000_3344) begin errors++; $display("FAIL bp_data: got %h required 00003344", hold); end
    a_req_op = 3'b010; a_req_addr = BASE; a_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== hold || a_req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b rdata=%h ready=%b required 1/%h/0", k, a_rsp_valid, a_rsp_rdata, a_req_ready, hold);
      end
      @(posedge clock); #1;
    end
    a_rsp_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_handshake: got ready=%b valid=%b required 1/0", a_req_ready, a_rsp_valid);
    end
    @(posedge clock); #1;
    a_req_valid = 1'b0;
    checks++;
    if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got ready=%b required 0", a_req_ready); end
    n = 0;
    while (!a_rsp_valid && n < 40) begin @(posedge clock); #1; n++; end
    checks++;
    if (a_rsp_rdata !== 32'h5A22_3344 || n !== LAT_A) begin
      errors++; $display("FAIL bp_second_rsp: got %h after %0d required 5a223344 after %0d", a_rsp_rdata, n, LAT_A);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_busy();
    bit [31:0] rd, erd; bit err, eerr, ra, bo; int lat, n;
    ref_access(1, 3'b010, BASE + 32'h10, 32'h0, erd, eerr);
    a_xact(1, 3'b010, BASE + 32'h10, 32'h0, rd, err, lat, ra, bo);
    a_req_wren = 1; a_req_op = 3'b010; a_req_addr = BASE + 32'h10; a_req_wdata = 32'hCAFE_F00D; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    a_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0) begin
      errors++; $display("FAIL busy_reset_outputs: got valid=%b ready=%b required 0/0", a_rsp_valid, a_req_ready);
    end
    repeat (2) @(posedge clock);
    #1; reset_n = 1'b1;
    @(posedge clock); #1;
    a_xact(0, 3'b010, BASE + 32'h10, 32'h0, rd, err, lat, ra, bo);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL busy_reset_dropped: got %h required 00000000", rd); end
    // Reset while a response is waiting for rsp_ready: it must not reappear.
    a_rsp_ready = 1'b0;
    a_req_wren = 0; a_req_addr = BASE; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 40) begin @(posedge clock); #1; n++; end
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    a_rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++; $display("FAIL resp_reset_discard: got valid=%b ready=%b required 0/1", a_rsp_valid, a_req_ready);
    end
  endtask

  task automatic test_random();
    bit [31:0] rd, erd, addr, wd; bit err, eerr, ra, bo, wren; bit [2:0] op; int lat, r;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      ref_access(1, 3'b010, BASE + 4 * i, wd, erd, eerr);
      a_xact(1, 3'b010, BASE + 4 * i, wd, rd, err, lat, ra, bo);
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) addr = BASE - 4 + $urandom_range(0, 3);
      else if (r == 1) addr = BASE + DEPTH * 4 + $urandom_range(0, 7);
      else addr = BASE + $urandom_range(0, 63);
      op = 3'($urandom_range(0, 7));
      wren = 1'($urandom_range(0, 1));
      wd = $urandom;
      ref_access(wren, op, addr, wd, erd, eerr);
      a_xact(wren, op, addr, wd, rd, err, lat, ra, bo);
      checks++;
      if ({err, rd} !== {eerr, erd} || lat !== LAT_A) begin
        errors++; $display("FAIL rand%0d w=%b op=%b a=%h: got err=%b rd=%h lat=%0d required err=%b rd=%h lat=%0d",
                           i, wren, op, addr, err, rd, lat, eerr, erd, LAT_A);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit [31:0] bexp [8];
    int n;
    for (int i = 0; i < 8; i++) begin
      bexp[i] = $urandom;
      b_req_wren = 1; b_req_op = 3'b010; b_req_addr = BASE + 4 * i; b_req_wdata = bexp[i]; b_req_valid = 1'b1;
      n = 0;
      while (!b_req_ready && n < 50) begin @(posedge clock); #1; n++; end
      @(posedge clock); #1;
      b_req_valid = 1'b0;
      n = 0;
      while (!b_rsp_valid && n < 40) begin @(posedge clock); #1; n++; end
      @(posedge clock); #1;
    end
    b_req_wren = 0;
    for (int i = 0; i < 8; i++) begin
      b_req_addr = BASE + 4 * i; b_req_valid = 1'b1;
      n = 0;
      while (!b_req_ready && n < 50) begin @(posedge clock); #1; n++; end
      if (i > 0) begin
        checks++;
        if (n !== 0) begin errors++; $display("FAIL b2b_gap%0d: waited %0d cycles required 0", i, n); end
      end
      @(posedge clock); #1;
      @(posedge clock); #1;
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== bexp[i] || b_rsp_err !== 1'b0) begin
        errors++; $display("FAIL b2b_rsp%0d: got valid=%b rdata=%h required 1/%h", i, b_rsp_valid, b_rsp_rdata, bexp[i]);
      end
      @(posedge clock); #1;
    end
    b_req_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_backpressure();
    test_reset_busy();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
